// File: rtl/alu_issue_queue_if.sv
// Command and result channels between the issue queue and its producer/consumer.
// The queue sits on the slave side; the producer/consumer sits on the master side.
interface alu_issue_queue_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [3:0] cmd_a;
    logic [3:0] cmd_b;
    logic [2:0] cmd_sel;
    logic       res_valid;
    logic       res_ready;
    logic [3:0] res_y;
    logic       res_carry;
    logic       res_zero;
    logic [2:0] res_sel;

    modport master (
        output cmd_valid, cmd_a, cmd_b, cmd_sel, res_ready,
        input  cmd_ready, res_valid, res_y, res_carry, res_zero, res_sel
    );

    modport slave (
        input  cmd_valid, cmd_a, cmd_b, cmd_sel, res_ready,
        output cmd_ready, res_valid, res_y, res_carry, res_zero, res_sel
    );
endinterface

// File: rtl/alu_issue_queue.sv
// Issue queue for the 4-bit combinational ALU: a command FIFO whose head drives the ALU,
// and a registered valid/ready result slot that captures the ALU output on each pop.
module alu_issue_queue #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 8,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic                clk,
    input  logic                rst,
    alu_issue_queue_if.slave    bus,
    output logic [3:0]          alu_a,
    output logic [3:0]          alu_b,
    output logic [2:0]          alu_sel,
    input  logic [3:0]          alu_y,
    input  logic                alu_carry,
    output logic [CNT_W-1:0]    op_count,
    output logic [AW:0]         fifo_level
);
    typedef struct packed {
        logic [2:0] sel;
        logic [3:0] a;
        logic [3:0] b;
    } cmd_t;

    cmd_t        mem [DEPTH];
    cmd_t        head;
    logic [AW:0] wr_ptr, rd_ptr;
    logic        live;
    logic        full, empty, push, pop, consume;

    assign empty      = (wr_ptr == rd_ptr);
    assign full       = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    // live holds cmd_ready low through reset and releases it one cycle later
    assign bus.cmd_ready = live && !full;
    assign push       = bus.cmd_valid && bus.cmd_ready;
    assign consume    = bus.res_valid && bus.res_ready;
    assign pop        = !empty && (!bus.res_valid || bus.res_ready);
    assign fifo_level = wr_ptr - rd_ptr;

    // Head comes only from storage and registered pointers, never from cmd_*
    assign head    = empty ? '0 : mem[rd_ptr[AW-1:0]];
    assign alu_a   = head.a;
    assign alu_b   = head.b;
    assign alu_sel = head.sel;

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr[AW-1:0]] <= {bus.cmd_sel, bus.cmd_a, bus.cmd_b};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            live          <= 1'b0;
            op_count      <= '0;
            bus.res_valid <= 1'b0;
            bus.res_y     <= '0;
            bus.res_carry <= 1'b0;
            bus.res_zero  <= 1'b0;
            bus.res_sel   <= '0;
        end else begin
            live <= 1'b1;
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (consume)
                op_count <= op_count + 1'b1;
            if (pop) begin
                rd_ptr        <= rd_ptr + 1'b1;
                bus.res_valid <= 1'b1;
                bus.res_y     <= alu_y;
                bus.res_carry <= alu_carry;
                bus.res_zero  <= (alu_y == 4'b0);
                bus.res_sel   <= alu_sel;
            end else if (consume) begin
                bus.res_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_alu_issue_queue.sv
// Bench for alu_issue_queue: queue-based reference model compared every cycle, plus
// directed scenarios with hand-computed results.
module tb_alu_issue_queue;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] alu_a, alu_b, alu_y;
    logic [2:0] alu_sel;
    logic       alu_carry;
    logic [7:0] op_count;
    logic [2:0] fifo_level;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    alu_issue_queue_if bus ();

    alu_issue_queue #(.DEPTH(DEPTH), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .bus(bus),
        .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
        .alu_y(alu_y), .alu_carry(alu_carry),
        .op_count(op_count), .fifo_level(fifo_level)
    );

    // The ALU itself: 000 ADD 001 SUB 010 AND 011 OR 100 XOR 101 NOT 110 SHL 111 SHR
    function automatic logic [4:0] alu_f(input logic [2:0] s, input logic [3:0] a, input logic [3:0] b);
        case (s)
            3'd0: return {1'b0, a} + {1'b0, b};
            3'd1: return {1'b0, a} - {1'b0, b};
            3'd2: return {1'b0, a & b};
            3'd3: return {1'b0, a | b};
            3'd4: return {1'b0, a ^ b};
            3'd5: return {1'b0, ~a};
            3'd6: return {a[3], a[2:0], 1'b0};
            default: return {a[0], 1'b0, a[3:1]};
        endcase
    endfunction

    always_comb {alu_carry, alu_y} = alu_f(alu_sel, alu_a, alu_b);

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: commands in a queue, one result slot, a handshake counter
    logic [10:0] mq[$];
    logic        m_rv, m_c, m_z, m_live;
    logic [3:0]  m_y;
    logic [2:0]  m_s;
    logic [7:0]  m_cnt;
    bit          armed = 0;
    logic [8:0]  got[$];

    task automatic model_step();
        logic [10:0] h;
        logic [4:0]  r;
        bit do_push, do_pop, take;
        if (rst) begin
            mq.delete();
            m_rv = 0; m_y = 0; m_c = 0; m_z = 0; m_s = 0; m_cnt = 0; m_live = 0;
            armed = 1;
            return;
        end
        do_push = bus.cmd_valid && m_live && mq.size() < DEPTH;
        do_pop  = mq.size() > 0 && (!m_rv || bus.res_ready);
        take    = m_rv && bus.res_ready;
        if (take) m_cnt++;
        if (do_pop) begin
            h = mq.pop_front();
            r = alu_f(h[10:8], h[7:4], h[3:0]);
            m_y = r[3:0]; m_c = r[4]; m_z = (r[3:0] == 4'd0); m_s = h[10:8]; m_rv = 1;
        end else if (take) begin
            m_rv = 0;
        end
        if (do_push) mq.push_back({bus.cmd_sel, bus.cmd_a, bus.cmd_b});
        m_live = 1;
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    initial forever begin
        @(negedge clk);
        if (armed) begin
            logic [10:0] hd;
            logic [32:0] act, exp;
            hd  = (mq.size() > 0) ? mq[0] : 11'd0;
            exp = {m_live && (mq.size() < DEPTH), hd[7:4], hd[3:0], hd[10:8],
                   m_rv, m_y, m_c, m_z, m_s, m_cnt, 3'(mq.size())};
            act = {bus.cmd_ready, alu_a, alu_b, alu_sel, bus.res_valid, bus.res_y,
                   bus.res_carry, bus.res_zero, bus.res_sel, op_count, fifo_level};
            chk("cycle", 64'(act), 64'(exp));
            if (!rst && bus.res_valid && bus.res_ready)
                got.push_back({bus.res_sel, bus.res_carry, bus.res_zero, bus.res_y});
        end
    end

    task automatic push(input logic [2:0] s, input logic [3:0] a, input logic [3:0] b);
        int n = 0;
        bus.cmd_valid = 1'b1; bus.cmd_sel = s; bus.cmd_a = a; bus.cmd_b = b;
        @(negedge clk);
        while (!bus.cmd_ready && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk("push_accept", 64'(bus.cmd_ready), 64'd1);
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
    endtask

    initial begin
        int n0;
        bus.cmd_valid = 0; bus.cmd_a = 0; bus.cmd_b = 0; bus.cmd_sel = 0; bus.res_ready = 1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_cmd_ready", 64'(bus.cmd_ready), 64'd0);
        chk("rst_res_valid", 64'(bus.res_valid), 64'd0);
        chk("rst_level", 64'(fifo_level), 64'd0);
        chk("rst_op_count", 64'(op_count), 64'd0);
        rst = 0;
        @(posedge clk); #1;

        // ADD 9+8 -> y=1 carry=1
        push(3'd0, 4'd9, 4'd8);
        @(negedge clk);
        chk("head_a", 64'(alu_a), 64'd9);
        chk("head_b", 64'(alu_b), 64'd8);
        chk("head_sel", 64'(alu_sel), 64'd0);
        @(posedge clk); @(negedge clk);
        chk("add_res", 64'({bus.res_valid, bus.res_y, bus.res_carry, bus.res_zero, bus.res_sel}),
            64'({1'b1, 4'd1, 1'b1, 1'b0, 3'd0}));
        @(posedge clk); @(negedge clk);
        chk("op_count_1", 64'(op_count), 64'd1);
        @(posedge clk); #1;

        // SUB 3-5 then XOR 6^6
        push(3'd1, 4'd3, 4'd5);
        push(3'd4, 4'd6, 4'd6);
        repeat (4) @(posedge clk);
        #1;
        chk("order_add", 64'(got[0]), 64'({3'd0, 1'b1, 1'b0, 4'd1}));
        chk("order_sub", 64'(got[1]), 64'({3'd1, 1'b1, 1'b0, 4'd14}));
        chk("order_xor", 64'(got[2]), 64'({3'd4, 1'b0, 1'b1, 4'd0}));

        // Backpressure: slot holds first result, FIFO takes exactly DEPTH more
        bus.res_ready = 0;
        for (int k = 1; k <= 5; k++) push(3'd0, 4'(k), 4'd1);
        bus.cmd_valid = 1; bus.cmd_sel = 3'd0; bus.cmd_a = 4'd6; bus.cmd_b = 4'd1;
        @(negedge clk);
        chk("full_ready", 64'(bus.cmd_ready), 64'd0);
        chk("full_level", 64'(fifo_level), 64'd4);
        chk("hold_res", 64'({bus.res_valid, bus.res_y}), 64'({1'b1, 4'd2}));
        @(posedge clk); #1;
        bus.res_ready = 1;
        @(negedge clk);
        chk("pop_edge_ready", 64'(bus.cmd_ready), 64'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("after_pop_level", 64'(fifo_level), 64'd3);
        chk("after_pop_ready", 64'(bus.cmd_ready), 64'd1);
        @(posedge clk); #1;
        bus.cmd_valid = 0;
        repeat (8) @(posedge clk);
        #1;
        chk("drain_count", 64'(got.size()), 64'd9);
        for (int k = 0; k < 6; k++)
            chk("drain_y", 64'(got[3 + k][3:0]), 64'(k + 2));
        chk("op_count_9", 64'(op_count), 64'd9);

        // Wrap-around: 20 SHL commands under random res_ready
        fork
            for (int k = 0; k < 20; k++) push(3'd6, 4'(k % 16), 4'd0);
            begin
                repeat (40) begin
                    @(posedge clk); #1;
                    bus.res_ready = 1'($urandom_range(0, 1));
                end
                bus.res_ready = 1;
            end
        join
        bus.res_ready = 1;
        repeat (12) @(posedge clk);
        #1;
        chk("wrap_count", 64'(got.size()), 64'd29);
        for (int k = 0; k < 20; k++)
            chk("wrap_y", 64'(got[9 + k][3:0]), 64'((k * 2) % 16));
        chk("wrap_level", 64'(fifo_level), 64'd0);

        // Reset with one result pending and three commands queued
        bus.res_ready = 0;
        for (int k = 1; k <= 4; k++) push(3'd0, 4'(k), 4'(k));
        rst = 1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("mid_rst_state", 64'({bus.res_valid, fifo_level, op_count, alu_a, alu_b, alu_sel, bus.cmd_ready}),
            64'd0);
        rst = 0;
        bus.res_ready = 1;
        n0 = got.size();
        push(3'd0, 4'd2, 4'd3);
        repeat (3) @(posedge clk);
        #1;
        chk("post_rst_count", 64'(got.size()), 64'(n0 + 1));
        if (got.size() > n0)
            chk("post_rst_res", 64'(got[n0]), 64'({3'd0, 1'b0, 1'b0, 4'd5}));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
